// File: rtl/pipeline_stall_controller.sv
// Hazard and stall sequencer for the 5-stage MIPS core: load-use stalls, taken-branch
// flushes and the multi-cycle multiply hold of EX, plus a saturating stall-cycle counter.
module pipeline_stall_controller #(
  parameter int unsigned MUL_LATENCY = 4
) (
  input  logic        CLK,
  input  logic        Reset_L,
  input  logic [4:0]  ID_Rs,
  input  logic [4:0]  ID_Rt,
  input  logic        ID_UseRs,
  input  logic        ID_UseRt,
  input  logic        ID_MulOp,
  input  logic        EX_MemRead,
  input  logic [4:0]  EX_Rw,
  input  logic        EX_BranchTaken,
  input  logic        StatClear,
  output logic        PCWrite,
  output logic        IF_ID_Write,
  output logic        IF_Flush,
  output logic        ID_EX_Bubble,
  output logic        ID_EX_Hold,
  output logic        EX_MEM_Bubble,
  output logic        MulStart,
  output logic        MulBusy,
  output logic [15:0] StallCount
);

  typedef enum logic {
    RUN      = 1'b0,
    MUL_WAIT = 1'b1
  } state_e;

  localparam logic [3:0] CNT_INIT = 4'(MUL_LATENCY - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic        load_use_s;

  assign load_use_s = EX_MemRead && (EX_Rw != 5'd0) &&
                      ((ID_UseRs && (ID_Rs == EX_Rw)) || (ID_UseRt && (ID_Rt == EX_Rw)));

  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      state_q     <= RUN;
      cnt_q       <= 4'd0;
      stall_cnt_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Outputs stay 0 while reset is held, including the write enables.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    PCWrite       = 1'b0;
    IF_ID_Write   = 1'b0;
    IF_Flush      = 1'b0;
    ID_EX_Bubble  = 1'b0;
    ID_EX_Hold    = 1'b0;
    EX_MEM_Bubble = 1'b0;
    MulStart      = 1'b0;
    MulBusy       = 1'b0;
    if (Reset_L) begin
      case (state_q)
        RUN: begin
          PCWrite     = 1'b1;
          IF_ID_Write = 1'b1;
          if (EX_BranchTaken) begin
            IF_Flush     = 1'b1;
            ID_EX_Bubble = 1'b1;
          end else if (load_use_s) begin
            PCWrite      = 1'b0;
            IF_ID_Write  = 1'b0;
            ID_EX_Bubble = 1'b1;
          end else if (ID_MulOp) begin
            MulStart = 1'b1;
            state_d  = MUL_WAIT;
            cnt_d    = CNT_INIT;
          end else begin
            state_d = RUN;
          end
        end
        MUL_WAIT: begin
          ID_EX_Hold    = 1'b1;
          EX_MEM_Bubble = 1'b1;
          MulBusy       = 1'b1;
          cnt_d         = cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_d = RUN;
            cnt_d   = 4'd0;
          end else begin
            state_d = MUL_WAIT;
          end
        end
        default: begin
          state_d = RUN;
          cnt_d   = 4'd0;
        end
      endcase
    end else begin
      state_d = RUN;
      cnt_d   = 4'd0;
    end
  end

  // Clear wins over increment; the counter sticks at all-ones.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (StatClear) begin
      stall_cnt_d = 16'd0;
    end else if (!PCWrite && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  assign StallCount = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Randomized and directed bench for pipeline_stall_controller (latency 4 and 2 instances
// sharing inputs) against a cycle-level behavioural model.
module tb_pipeline_stall_controller;

  logic        CLK = 1'b0;
  logic        Reset_L;
  logic [4:0]  ID_Rs, ID_Rt, EX_Rw;
  logic        ID_UseRs, ID_UseRt, ID_MulOp, EX_MemRead, EX_BranchTaken, StatClear;

  logic        pcw4, ifw4, iff4, idb4, idh4, exb4, ms4, mb4;
  logic        pcw2, ifw2, iff2, idb2, idh2, exb2, ms2, mb2;
  logic [15:0] sc_dut4, sc_dut2;

  int checks = 0;
  int errors = 0;

  // Model state: remaining hold cycles and stall count, per latency.
  int hold4 = 0, hold2 = 0;
  int sc4 = 0, sc2 = 0;
  logic [7:0] exp4, exp2;

  localparam logic [7:0] V_NORM = 8'b1100_0000;
  localparam logic [7:0] V_BR   = 8'b1111_0000;
  localparam logic [7:0] V_LU   = 8'b0001_0000;
  localparam logic [7:0] V_MUL  = 8'b1100_0010;
  localparam logic [7:0] V_HOLD = 8'b0000_1101;

  wire [7:0] out4 = {pcw4, ifw4, iff4, idb4, idh4, exb4, ms4, mb4};
  wire [7:0] out2 = {pcw2, ifw2, iff2, idb2, idh2, exb2, ms2, mb2};

  always #5 CLK = ~CLK;

  pipeline_stall_controller #(.MUL_LATENCY(4)) dut4 (
    .CLK(CLK), .Reset_L(Reset_L), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt),
    .ID_UseRs(ID_UseRs), .ID_UseRt(ID_UseRt), .ID_MulOp(ID_MulOp),
    .EX_MemRead(EX_MemRead), .EX_Rw(EX_Rw), .EX_BranchTaken(EX_BranchTaken),
    .StatClear(StatClear), .PCWrite(pcw4), .IF_ID_Write(ifw4), .IF_Flush(iff4),
    .ID_EX_Bubble(idb4), .ID_EX_Hold(idh4), .EX_MEM_Bubble(exb4),
    .MulStart(ms4), .MulBusy(mb4), .StallCount(sc_dut4));

  pipeline_stall_controller #(.MUL_LATENCY(2)) dut2 (
    .CLK(CLK), .Reset_L(Reset_L), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt),
    .ID_UseRs(ID_UseRs), .ID_UseRt(ID_UseRt), .ID_MulOp(ID_MulOp),
    .EX_MemRead(EX_MemRead), .EX_Rw(EX_Rw), .EX_BranchTaken(EX_BranchTaken),
    .StatClear(StatClear), .PCWrite(pcw2), .IF_ID_Write(ifw2), .IF_Flush(iff2),
    .ID_EX_Bubble(idb2), .ID_EX_Hold(idh2), .EX_MEM_Bubble(exb2),
    .MulStart(ms2), .MulBusy(mb2), .StallCount(sc_dut2));

  function automatic logic hazard();
    return EX_MemRead && (EX_Rw != 5'd0) &&
           ((ID_UseRs && ID_Rs == EX_Rw) || (ID_UseRt && ID_Rt == EX_Rw));
  endfunction

  function automatic logic [7:0] predict(input int hold);
    if (!Reset_L)        return 8'h00;
    if (hold > 0)        return V_HOLD;
    if (EX_BranchTaken)  return V_BR;
    if (hazard())        return V_LU;
    if (ID_MulOp)        return V_MUL;
    return V_NORM;
  endfunction

  task automatic idle_inputs();
    ID_Rs = 5'd0; ID_Rt = 5'd0; EX_Rw = 5'd0;
    ID_UseRs = 1'b0; ID_UseRt = 1'b0; ID_MulOp = 1'b0;
    EX_MemRead = 1'b0; EX_BranchTaken = 1'b0; StatClear = 1'b0;
  endtask

  // Settle current inputs and form the expected output vectors.
  task automatic settle();
    #1;
    exp4 = predict(hold4);
    exp2 = predict(hold2);
  endtask

  // Advance one clock and update the model with the inputs seen at that edge.
  task automatic tick();
    logic [7:0] e4, e2;
    e4 = predict(hold4);
    e2 = predict(hold2);
    @(posedge CLK);
    if (StatClear) sc4 = 0; else if (!e4[7] && sc4 < 65535) sc4++;
    if (StatClear) sc2 = 0; else if (!e2[7] && sc2 < 65535) sc2++;
    if (hold4 > 0) hold4--; else if (e4[1]) hold4 = 3;
    if (hold2 > 0) hold2--; else if (e2[1]) hold2 = 1;
    @(negedge CLK);
  endtask

  task automatic drain();
    idle_inputs();
    for (int i = 0; i < 6; i++) tick();
  endtask

  task automatic test_reset();
    idle_inputs();
    Reset_L = 1'b0;
    #3;
    checks++;
    if (out4 !== 8'h00 || out2 !== 8'h00) begin
      errors++; $display("FAIL reset_outputs got %b/%b want 00000000", out4, out2);
    end
    checks++;
    if (sc_dut4 !== 16'd0 || sc_dut2 !== 16'd0) begin
      errors++; $display("FAIL reset_count got %0d/%0d want 0", sc_dut4, sc_dut2);
    end
    @(negedge CLK);
    Reset_L = 1'b1;
    hold4 = 0; hold2 = 0; sc4 = 0; sc2 = 0;
    settle();
    checks++;
    if (out4 !== V_NORM || out4 !== exp4) begin
      errors++; $display("FAIL post_reset_run got %b want %b", out4, V_NORM);
    end
    tick();
  endtask

  task automatic test_load_use();
    int base;
    base = sc4;
    idle_inputs();
    EX_MemRead = 1'b1; EX_Rw = 5'd3; ID_Rs = 5'd3; ID_UseRs = 1'b1;
    settle();
    checks++;
    if (out4 !== V_LU || out2 !== exp2) begin
      errors++; $display("FAIL load_use_stall got %b want %b", out4, V_LU);
    end
    tick();
    idle_inputs();
    settle();
    checks++;
    if (out4 !== V_NORM) begin
      errors++; $display("FAIL load_use_release got %b want %b", out4, V_NORM);
    end
    checks++;
    if (sc_dut4 !== 16'(base + 1) || sc_dut4 !== 16'(sc4)) begin
      errors++; $display("FAIL load_use_count got %0d want %0d", sc_dut4, base + 1);
    end
    tick();
  endtask

  task automatic test_reg0_unused();
    idle_inputs();
    EX_MemRead = 1'b1; EX_Rw = 5'd0; ID_Rs = 5'd0; ID_UseRs = 1'b1;
    settle();
    checks++;
    if (out4 !== V_NORM) begin
      errors++; $display("FAIL reg0_no_stall got %b want %b", out4, V_NORM);
    end
    tick();
    EX_Rw = 5'd7; ID_Rs = 5'd1; ID_Rt = 5'd7; ID_UseRt = 1'b0;
    settle();
    checks++;
    if (out4 !== V_NORM) begin
      errors++; $display("FAIL unused_rt_no_stall got %b want %b", out4, V_NORM);
    end
    tick();
    ID_UseRt = 1'b1;
    settle();
    checks++;
    if (out4 !== V_LU) begin
      errors++; $display("FAIL rt_stall got %b want %b", out4, V_LU);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_branch_priority();
    idle_inputs();
    EX_BranchTaken = 1'b1; EX_MemRead = 1'b1; EX_Rw = 5'd4;
    ID_Rs = 5'd4; ID_UseRs = 1'b1; ID_MulOp = 1'b1;
    settle();
    checks++;
    if (out4 !== V_BR || out2 !== V_BR) begin
      errors++; $display("FAIL branch_priority got %b/%b want %b", out4, out2, V_BR);
    end
    tick();
    idle_inputs();
    settle();
    checks++;
    if (out4 !== V_NORM) begin
      errors++; $display("FAIL branch_stays_run got %b want %b", out4, V_NORM);
    end
    tick();
  endtask

  // ID_MulOp held high: the second start must land exactly at T+MUL_LATENCY.
  task automatic test_multiply();
    logic [7:0] want4 [0:5];
    logic [7:0] want2 [0:5];
    int base;
    want4 = '{V_MUL, V_HOLD, V_HOLD, V_HOLD, V_MUL, V_HOLD};
    want2 = '{V_MUL, V_HOLD, V_MUL, V_HOLD, V_MUL, V_HOLD};
    base = sc4;
    idle_inputs();
    ID_MulOp = 1'b1;
    for (int c = 0; c < 6; c++) begin
      settle();
      checks++;
      if (out4 !== want4[c] || out4 !== exp4) begin
        errors++; $display("FAIL mul4_cycle%0d got %b want %b", c, out4, want4[c]);
      end
      checks++;
      if (out2 !== want2[c] || out2 !== exp2) begin
        errors++; $display("FAIL mul2_cycle%0d got %b want %b", c, out2, want2[c]);
      end
      if (c == 4) begin
        checks++;
        if (sc_dut4 !== 16'(base + 3)) begin
          errors++; $display("FAIL mul4_count got %0d want %0d", sc_dut4, base + 3);
        end
      end
      tick();
    end
    drain();
  endtask

  task automatic test_reset_mul_wait();
    idle_inputs();
    ID_MulOp = 1'b1;
    tick();
    idle_inputs();
    tick();
    #2;
    Reset_L = 1'b0;
    #1;
    checks++;
    if (out4 !== 8'h00 || out2 !== 8'h00) begin
      errors++; $display("FAIL reset_mid_hold got %b/%b want 00000000", out4, out2);
    end
    checks++;
    if (sc_dut4 !== 16'd0) begin
      errors++; $display("FAIL reset_mid_hold_count got %0d want 0", sc_dut4);
    end
    hold4 = 0; hold2 = 0; sc4 = 0; sc2 = 0;
    @(negedge CLK);
    Reset_L = 1'b1;
    settle();
    checks++;
    if (out4 !== V_NORM || pcw4 !== 1'b1) begin
      errors++; $display("FAIL after_reset_run got %b want %b", out4, V_NORM);
    end
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      ID_Rs = 5'($urandom_range(0, 3)); ID_Rt = 5'($urandom_range(0, 3));
      EX_Rw = 5'($urandom_range(0, 3));
      ID_UseRs = 1'($urandom); ID_UseRt = 1'($urandom);
      EX_MemRead = 1'($urandom);
      ID_MulOp = ($urandom_range(0, 3) == 0);
      EX_BranchTaken = (hold4 == 0 && hold2 == 0) ? ($urandom_range(0, 5) == 0) : 1'b0;
      StatClear = ($urandom_range(0, 40) == 0);
      settle();
      checks++;
      if (out4 !== exp4) begin
        errors++; $display("FAIL rand4_out[%0d] got %b want %b", i, out4, exp4);
      end
      checks++;
      if (out2 !== exp2) begin
        errors++; $display("FAIL rand2_out[%0d] got %b want %b", i, out2, exp2);
      end
      checks++;
      if (sc_dut4 !== 16'(sc4) || sc_dut2 !== 16'(sc2)) begin
        errors++; $display("FAIL rand_count[%0d] got %0d/%0d want %0d/%0d",
                           i, sc_dut4, sc_dut2, sc4, sc2);
      end
      tick();
    end
    drain();
  endtask

  task automatic test_saturation();
    idle_inputs();
    EX_MemRead = 1'b1; EX_Rw = 5'd5; ID_Rs = 5'd5; ID_UseRs = 1'b1;
    for (int i = 0; i < 70000; i++) tick();
    settle();
    checks++;
    if (sc_dut4 !== 16'hFFFF || sc4 != 65535) begin
      errors++; $display("FAIL saturate got %h want ffff", sc_dut4);
    end
    StatClear = 1'b1;
    tick();
    StatClear = 1'b0;
    settle();
    checks++;
    if (sc_dut4 !== 16'd0 || sc_dut2 !== 16'(sc2)) begin
      errors++; $display("FAIL clear_in_stall got %0d want 0", sc_dut4);
    end
    tick();
    settle();
    checks++;
    if (sc_dut4 !== 16'd1) begin
      errors++; $display("FAIL count_after_clear got %0d want 1", sc_dut4);
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_reg0_unused();
    test_branch_priority();
    test_multiply();
    test_reset_mul_wait();
    test_random();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_stall_controller.md
# pipeline_stall_controller

Sequences the pipeline registers of the 5-stage MIPS core around the operand-forwarding network. It detects load-use hazards and taken branches, and holds EX for the multi-cycle multiply unit. From these it drives PC/IF-ID write enables, bubble/flush controls and multiply start. It sits in ID next to the forwarding unit and keeps a saturating stall-cycle counter for performance measurement.

## Interface
- MUL_LATENCY, 4: cycles a multiply occupies EX. Legal range 2..15.
- CLK  in  1  clock; all state updates on rising edge.
- Reset_L  in  1  asynchronous, active-low reset.
- ID_Rs, ID_Rt  in  5 each  source registers of the instruction in ID.
- ID_UseRs, ID_UseRt  in  1 each  the ID instruction actually reads Rs / Rt.
- ID_MulOp  in  1  the ID instruction is a multi-cycle multiply.
- EX_MemRead  in  1  the EX instruction is a load.
- EX_Rw  in  5  destination register of the EX instruction.
- EX_BranchTaken  in  1  a branch or jump resolved taken in EX this cycle.
- StatClear  in  1  synchronous clear of StallCount.
- PCWrite  out  1  PC register write enable.
- IF_ID_Write  out  1  IF/ID register write enable.
- IF_Flush  out  1  load a NOP into IF/ID.
- ID_EX_Bubble  out  1  load a NOP into ID/EX.
- ID_EX_Hold  out  1  freeze the ID/EX register.
- EX_MEM_Bubble  out  1  load a NOP into EX/MEM.
- MulStart  out  1  one-cycle start pulse to the multiply unit.
- MulBusy  out  1  multiply occupying EX.
- StallCount  out  16  saturating count of cycles with PCWrite=0.

## Operation
- States are RUN and MUL_WAIT, with a 4-bit down-counter cnt.
- Hazard term: LoadUse = EX_MemRead & (EX_Rw≠0) & ((ID_UseRs & ID_Rs==EX_Rw) | (ID_UseRt & ID_Rt==EX_Rw)).
- Outputs are combinational from state and inputs. Priority in RUN, highest first:
  - EX_BranchTaken: IF_Flush=1, ID_EX_Bubble=1, PCWrite=1, IF_ID_Write=1, MulStart=0. LoadUse and ID_MulOp are ignored (the ID instruction is wrong-path). Stay in RUN.
  - LoadUse: PCWrite=0, IF_ID_Write=0, ID_EX_Bubble=1, MulStart=0. Stay in RUN.
    - The bubble clears the hazard next cycle, so every load-use stall is exactly 1 cycle.
    - A dependent multiply gets MulStart one cycle later.
  - ID_MulOp: MulStart=1; PCWrite and IF_ID_Write stay 1. Next state is MUL_WAIT, with cnt loaded to MUL_LATENCY-1.
  - Otherwise: PCWrite=1, IF_ID_Write=1, all other controls 0.
- In MUL_WAIT:
  - PCWrite=0, IF_ID_Write=0, ID_EX_Hold=1, EX_MEM_Bubble=1, MulBusy=1. All other controls 0.
  - cnt decrements each cycle.
  - When cnt==1, next state is RUN and cnt becomes 0.
  - EX_BranchTaken, LoadUse and ID_MulOp are ignored. A branch cannot be in EX during a multiply, and the bench asserts this.
- StallCount:
  - StatClear=1 sets it to 0; clear has priority over increment.
  - Otherwise it increments when PCWrite=0 and saturates at 16'hFFFF.

## Timing
- Reset (Reset_L=0, asynchronous): state=RUN, cnt=0, StallCount=0.
  - While reset is asserted, all outputs are 0, including PCWrite and IF_ID_Write.
  - Reset asserted during MUL_WAIT aborts the multiply hold immediately.
- First rising edge with Reset_L=1 runs normal RUN behaviour.
- Load-use: stall outputs appear in the same cycle as the hazard. Latency is 0 and duration is 1 cycle.
- Multiply:
  - MulStart in cycle T.
  - MulBusy/hold in cycles T+1 .. T+MUL_LATENCY-1, i.e. MUL_LATENCY-1 stall cycles.
  - PCWrite returns to 1 in cycle T+MUL_LATENCY.
- A new multiply in ID on the exit cycle is not accepted until the state is RUN. The earliest back-to-back MulStart is cycle T+MUL_LATENCY.
- StallCount is registered and reflects a stall cycle one edge later.

## Test plan
- Load-use: lw $3 in EX (EX_MemRead=1, EX_Rw=3), ID_Rs=3 with ID_UseRs=1 → one cycle of PCWrite=0, IF_ID_Write=0, ID_EX_Bubble=1. Next cycle all normal. StallCount=1.
- Register-0 and unused-operand cases: EX_Rw=0 with ID_Rs=0, then ID_Rt match with ID_UseRt=0 → no stall in either case.
- Branch priority: EX_BranchTaken=1 together with LoadUse=1 and ID_MulOp=1 → IF_Flush=1, ID_EX_Bubble=1, PCWrite=1, MulStart=0.
- Multiply, MUL_LATENCY=4: ID_MulOp=1 at cycle 10 → MulStart at 10, MulBusy/ID_EX_Hold/EX_MEM_Bubble at 11–13, PCWrite=1 at 14. StallCount +3. Repeat with MUL_LATENCY=2 → a single hold cycle.
- Reset during MUL_WAIT: pull Reset_L low mid-hold → all outputs 0 at once and StallCount=0. After release, state is RUN with PCWrite=1.
- Saturation and clear: force 70000 stall cycles → StallCount holds 16'hFFFF. StatClear=1 in a stall cycle → StallCount=0 next edge.
